// File: rtl/pdm_decimator.sv
// PDM microphone front end: generates the mic clock, samples the 1-bit stream on each
// falling mic-clock toggle and box-car decimates DECIMATION bits into an unsigned 16-bit word.
module pdm_decimator #(
    parameter int CLK_HALF    = 20,
    parameter int DECIMATION  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        enable_i,
    output logic        done_o,
    output logic [15:0] data_o,
    output logic        pdm_clk_o,
    input  logic        pdm_data_i,
    output logic        pdm_lrsel_o
);

    // state  | meaning
    // S_IDLE | enable_i low; mic clock parked low, counters held at zero
    // S_RUN  | mic clock running, bits being accumulated into the current word

    localparam int LOG2_DEC = $clog2(DECIMATION);
    localparam int CNT_W    = LOG2_DEC + 1;
    localparam int DIV_W    = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam int SHIFT    = 16 - LOG2_DEC;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HALF - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_active;

    logic [SYNC_STAGES-1:0]  r_sync;
    logic [DIV_W-1:0]        r_div;
    logic                    r_pdm_clk;
    logic [LOG2_DEC-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]        r_ones_cnt;
    logic                    r_done;
    logic [15:0]             r_data;

    logic                    w_tick;
    logic                    w_fall;
    logic                    w_bit;
    logic                    w_last_bit;
    logic [CNT_W-1:0]        w_ones_total;
    logic [16:0]             w_scaled;
    logic [15:0]             w_pcm;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counting only starts the cycle after entering RUN, so the first rise lands
    // exactly CLK_HALF cycles after enable_i is first sampled high.
    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_active = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pdm_data_i};
        end
    end

    assign w_bit        = r_sync[SYNC_STAGES-1];
    assign w_tick       = w_active && (r_div == DIV_LAST);
    assign w_fall       = w_tick && r_pdm_clk;
    assign w_last_bit   = w_fall && (&r_bit_cnt);
    assign w_ones_total = r_ones_cnt + CNT_W'(w_bit);

    // A full word of ones scales to 65536, which is clipped to the top code.
    assign w_scaled = 17'(w_ones_total) << SHIFT;
    assign w_pcm    = w_scaled[16] ? 16'hFFFF : w_scaled[15:0];

    always_ff @(posedge clock_i) begin
        if (reset_i || !w_active) begin
            r_div      <= '0;
            r_pdm_clk  <= 1'b0;
            r_bit_cnt  <= '0;
            r_ones_cnt <= '0;
        end else begin
            if (w_tick) begin
                r_div     <= '0;
                r_pdm_clk <= ~r_pdm_clk;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            if (w_last_bit) begin
                r_bit_cnt  <= '0;
                r_ones_cnt <= '0;
            end else if (w_fall) begin
                r_bit_cnt  <= r_bit_cnt + LOG2_DEC'(1);
                r_ones_cnt <= w_ones_total;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_done <= 1'b0;
            r_data <= 16'h0000;
        end else begin
            r_done <= w_last_bit;
            if (w_last_bit) begin
                r_data <= w_pcm;
            end
        end
    end

    assign done_o      = r_done;
    assign data_o      = r_data;
    assign pdm_clk_o   = r_pdm_clk;
    assign pdm_lrsel_o = 1'b0;

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: a default instance and a small (CLK_HALF=2, DECIMATION=4) one,
// driven by a mic model that presents the next bit after each falling mic-clock edge.
module tb_pdm_decimator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i;
    logic        en_d, en_s, din_d, din_s;
    logic        done_d, done_s, pclk_d, pclk_s, lr_d, lr_s;
    logic [15:0] data_d, data_s;

    pdm_decimator u_dut (
        .clock_i(clk), .reset_i(reset_i), .enable_i(en_d), .done_o(done_d),
        .data_o(data_d), .pdm_clk_o(pclk_d), .pdm_data_i(din_d), .pdm_lrsel_o(lr_d)
    );

    pdm_decimator #(.CLK_HALF(2), .DECIMATION(4), .SYNC_STAGES(2)) u_small (
        .clock_i(clk), .reset_i(reset_i), .enable_i(en_s), .done_o(done_s),
        .data_o(data_s), .pdm_clk_o(pclk_s), .pdm_data_i(din_s), .pdm_lrsel_o(lr_s)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] q_d[$];
    logic [15:0] q_s[$];
    int bits_d = 0, ones_d = 0, bits_s = 0, ones_s = 0;
    int first_d = 0, first_s = 0, last_d = 0, last_s = 0;
    bit per_ok_d = 0, per_ok_s = 0;
    logic prev_done_d = 0, prev_done_s = 0, prev_pclk_d = 0;
    int rise_n_d = 0, rise1_d = 0, rise2_d = 0;
    logic [15:0] exp_d, exp_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat_word(input int ones, input int log2d);
        longint s;
        s = longint'(ones) << (16 - log2d);
        if (s > 65535) return 16'hFFFF;
        return s[15:0];
    endfunction

    function automatic logic pat(input int mode, input int i);
        logic [31:0] r;
        case (mode)
            0: return 1'b1;
            1: return 1'b0;
            2: return (i % 2) == 0;
            3: return (i % 4) == 0;
            4: return i < 48;
            default: begin
                r = $urandom_range(0, 1);
                return r[0];
            end
        endcase
    endfunction

    // Scoreboard consumers: every done pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (done_d) begin
            chk("done_d_single", 32'(prev_done_d), 32'd0);
            chk("done_d_expected", 32'(q_d.size() > 0), 32'd1);
            if (q_d.size() > 0) begin
                exp_d = q_d.pop_front();
                chk("data_d", 32'(data_d), 32'(exp_d));
            end
            if (first_d != 0) begin
                chk("first_done_d", 32'(cyc), 32'(first_d));
                first_d = 0;
            end else if (per_ok_d) begin
                chk("period_d", 32'(cyc - last_d), 32'd2560);
            end
            last_d   = cyc;
            per_ok_d = 1;
        end
        prev_done_d = done_d;
        if (!prev_pclk_d && pclk_d) begin
            if (rise_n_d == 0) rise1_d = cyc;
            else if (rise_n_d == 1) rise2_d = cyc;
            rise_n_d++;
        end
        prev_pclk_d = pclk_d;
    end

    always @(negedge clk) begin
        if (done_s) begin
            chk("done_s_single", 32'(prev_done_s), 32'd0);
            chk("done_s_expected", 32'(q_s.size() > 0), 32'd1);
            if (q_s.size() > 0) begin
                exp_s = q_s.pop_front();
                chk("data_s", 32'(data_s), 32'(exp_s));
            end
            if (first_s != 0) begin
                chk("first_done_s", 32'(cyc), 32'(first_s));
                first_s = 0;
            end else if (per_ok_s) begin
                chk("period_s", 32'(cyc - last_s), 32'd16);
            end
            last_s   = cyc;
            per_ok_s = 1;
        end
        prev_done_s = done_s;
    end

    task automatic wait_fall(input int w, output bit ok);
        logic prev, cur;
        ok   = 0;
        prev = w ? pclk_s : pclk_d;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            cur = w ? pclk_s : pclk_d;
            if (prev && !cur) ok = 1;
            prev = cur;
        end
    endtask

    task automatic send_bit(input int w, input logic b);
        bit ok;
        if (w == 0) begin
            din_d = b;
            if (bits_d == 63) begin
                q_d.push_back(sat_word(ones_d + int'(b), 6));
                bits_d = 0;
                ones_d = 0;
            end else begin
                bits_d++;
                ones_d += int'(b);
            end
        end else begin
            din_s = b;
            if (bits_s == 3) begin
                q_s.push_back(sat_word(ones_s + int'(b), 2));
                bits_s = 0;
                ones_s = 0;
            end else begin
                bits_s++;
                ones_s += int'(b);
            end
        end
        wait_fall(w, ok);
        chk(w ? "fall_timeout_s" : "fall_timeout_d", 32'(ok), 32'd1);
    endtask

    task automatic send_word(input int w, input int mode);
        for (int i = 0; i < (w ? 4 : 64); i++) send_bit(w, pat(mode, i));
    endtask

    task automatic wait_drain(input int w);
        for (int n = 0; n < 3000 && (w ? q_s.size() : q_d.size()) > 0; n++) @(negedge clk);
        chk(w ? "drain_s" : "drain_d", 32'(w ? q_s.size() : q_d.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        reset_i = 1'b1;
        en_d    = 1'b1;
        en_s    = 1'b1;
        din_d   = 1'b1;
        din_s   = 1'b1;

        // Reset held with enable and data high
        repeat (30) begin
            @(negedge clk);
            chk("rst_pclk_d", 32'(pclk_d), 32'd0);
            chk("rst_done_d", 32'(done_d), 32'd0);
            chk("rst_data_d", 32'(data_d), 32'h0);
            chk("rst_pclk_s", 32'(pclk_s), 32'd0);
            chk("rst_done_s", 32'(done_s), 32'd0);
            chk("rst_data_s", 32'(data_s), 32'h0);
        end
        chk("lrsel_d", 32'(lr_d), 32'd0);

        // Release with enable already high: first pulse 2561 sampled cycles later
        reset_i  = 1'b0;
        en_s     = 1'b0;
        rel      = cyc;
        rise_n_d = 0;
        first_d  = cyc + 2561;
        send_word(0, 0);
        chk("first_rise_d", 32'(rise1_d), 32'(rel + 21));
        chk("pclk_period_d", 32'(rise2_d - rise1_d), 32'd40);
        send_word(0, 0);
        send_word(0, 0);

        // Zeros, alternating, one-in-four
        send_word(0, 1);
        send_word(0, 2);
        send_word(0, 3);

        // Drop enable in the done cycle; pulse still issued, data held
        en_d = 1'b0;
        repeat (3) @(negedge clk);
        wait_drain(0);
        chk("hold_after_disable", 32'(data_d), 32'h4000);

        // Partial word of 30 bits, then disable while the mic clock is high
        en_d    = 1'b1;
        first_d = cyc + 2561;
        for (int i = 0; i < 30; i++) send_bit(0, pat(2, i));
        repeat (25) @(negedge clk);
        en_d   = 1'b0;
        bits_d = 0;
        ones_d = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("idle_pclk_d", 32'(pclk_d), 32'd0);
            chk("idle_done_d", 32'(done_d), 32'd0);
        end
        chk("idle_hold_d", 32'(data_d), 32'h4000);
        en_d    = 1'b1;
        first_d = cyc + 2561;
        send_word(0, 0);

        // One-cycle reset at bit 50 of a word
        for (int i = 0; i < 50; i++) send_bit(0, pat(2, i));
        reset_i = 1'b1;
        @(negedge clk);
        chk("midrst_done_d", 32'(done_d), 32'd0);
        chk("midrst_data_d", 32'(data_d), 32'h0);
        chk("midrst_pclk_d", 32'(pclk_d), 32'd0);
        reset_i = 1'b0;
        bits_d  = 0;
        ones_d  = 0;
        first_d = cyc + 2561;
        send_word(0, 4);
        wait_drain(0);
        en_d = 1'b0;

        // Small instance with random bits
        en_s    = 1'b1;
        first_s = cyc + 17;
        for (int k = 0; k < 8; k++) send_word(1, 5);
        wait_drain(1);
        en_s = 1'b0;

        repeat (5) @(negedge clk);
        chk("final_q_d", 32'(q_d.size()), 32'd0);
        chk("final_q_s", 32'(q_s.size()), 32'd0);
        chk("lrsel_s", 32'(lr_s), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
